// File: rtl/laser500_pkg.sv
// Shared definitions for the laser500 ioctl upload path: reader FSM states,
// region index codes and the fill byte returned on failed reads.
package laser500_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } upload_state_t;

    localparam logic [7:0] IDX_RAM   = 8'd0;
    localparam logic [7:0] IDX_VRAM  = 8'd1;
    localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage

// File: rtl/ioctl_upload_reader.sv
// Serves host upload byte reads from main RAM / video RAM over a req/ack memory port.
// Define UPLOAD_CHECKSUM_EN to add an 8-bit wrapping checksum of delivered bytes.
module ioctl_upload_reader
    import laser500_pkg::*;
#(
    parameter logic [23:0] RAM_BASE    = 24'h000000,
    parameter logic [24:0] RAM_SIZE    = 25'h0010000,
    parameter logic [23:0] VRAM_BASE   = 24'h010000,
    parameter logic [24:0] VRAM_SIZE   = 25'h0004000,
    parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_index,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic        mem_rd,
    output logic [23:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic        err,
`ifdef UPLOAD_CHECKSUM_EN
    output logic [7:0]  checksum,
`endif
    output logic [24:0] byte_count
);

    localparam logic [7:0] TMO_LAST = ACK_TIMEOUT - 8'd1;

    upload_state_t state, state_nxt;

    logic        upload_q;
    logic [7:0]  tcnt, tcnt_nxt;
    logic [7:0]  din_nxt;
    logic        wait_nxt;
    logic        rd_nxt;
    logic [23:0] addr_nxt;
    logic        err_nxt;
    logic [24:0] cnt_nxt;
    logic        rd_ok;
    logic        up_rise;
`ifdef UPLOAD_CHECKSUM_EN
    logic [7:0]  ck_nxt;
`endif

    // Range check uses the full 25-bit offset so a wrapped 24-bit address never aliases in.
    function automatic logic region_ok(input logic [7:0] idx, input logic [24:0] a);
        return ((idx == IDX_RAM)  && (a < RAM_SIZE)) ||
               ((idx == IDX_VRAM) && (a < VRAM_SIZE));
    endfunction

    function automatic logic [23:0] region_addr(input logic [7:0] idx, input logic [23:0] a);
        return ((idx == IDX_VRAM) ? VRAM_BASE : RAM_BASE) + a;
    endfunction

    assign rd_ok   = ioctl_rd && ioctl_upload;
    assign up_rise = ioctl_upload && !upload_q;

    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        din_nxt   = ioctl_din;
        wait_nxt  = ioctl_wait;
        rd_nxt    = mem_rd;
        addr_nxt  = mem_addr;
        err_nxt   = err;
        cnt_nxt   = byte_count;
`ifdef UPLOAD_CHECKSUM_EN
        ck_nxt    = checksum;
`endif

        if (up_rise) begin
            err_nxt = 1'b0;
            cnt_nxt = '0;
`ifdef UPLOAD_CHECKSUM_EN
            ck_nxt  = '0;
`endif
        end

        case (state)
            IDLE: begin
                tcnt_nxt = '0;
                if (ioctl_wait) begin
                    // single-cycle stall left over from a rejected access
                    wait_nxt = 1'b0;
                    if (rd_ok) err_nxt = 1'b1;
                end else if (rd_ok) begin
                    wait_nxt = 1'b1;
                    if (region_ok(ioctl_index, ioctl_addr)) begin
                        addr_nxt  = region_addr(ioctl_index, ioctl_addr[23:0]);
                        rd_nxt    = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        din_nxt = FILL_BYTE;
                        err_nxt = 1'b1;
`ifdef UPLOAD_CHECKSUM_EN
                        ck_nxt  = ck_nxt + FILL_BYTE;
`endif
                    end
                end
            end

            REQ: begin
                if (rd_ok) err_nxt = 1'b1;
                if (mem_ack) begin
                    din_nxt   = mem_data;
                    rd_nxt    = 1'b0;
                    wait_nxt  = 1'b0;
                    cnt_nxt   = cnt_nxt + 25'd1;
                    state_nxt = IDLE;
`ifdef UPLOAD_CHECKSUM_EN
                    ck_nxt    = ck_nxt + mem_data;
`endif
                end else if (!ioctl_upload) begin
                    // host gave up: release it now, let the memory cycle finish in DRAIN
                    wait_nxt  = 1'b0;
                    state_nxt = DRAIN;
                end else if (tcnt == TMO_LAST) begin
                    din_nxt   = FILL_BYTE;
                    wait_nxt  = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = DRAIN;
`ifdef UPLOAD_CHECKSUM_EN
                    ck_nxt    = ck_nxt + FILL_BYTE;
`endif
                end else begin
                    tcnt_nxt = tcnt + 8'd1;
                end
            end

            DRAIN: begin
                if (rd_ok) err_nxt = 1'b1;
                if (mem_ack) begin
                    rd_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            upload_q   <= 1'b0;
            tcnt       <= '0;
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            err        <= 1'b0;
            byte_count <= '0;
`ifdef UPLOAD_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            upload_q   <= ioctl_upload;
            tcnt       <= tcnt_nxt;
            ioctl_din  <= din_nxt;
            ioctl_wait <= wait_nxt;
            mem_rd     <= rd_nxt;
            mem_addr   <= addr_nxt;
            err        <= err_nxt;
            byte_count <= cnt_nxt;
`ifdef UPLOAD_CHECKSUM_EN
            checksum   <= ck_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Scoreboard bench for ioctl_upload_reader: expected bytes are queued when a
// read is issued and compared when the DUT releases ioctl_wait.
module tb_ioctl_upload_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_index;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        mem_rd;
    logic [23:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic        err;
    logic [24:0] byte_count;
`ifdef UPLOAD_CHECKSUM_EN
    logic [7:0]  checksum;
    logic [7:0]  model_ck;
`endif

    always #5 clk = ~clk;

    ioctl_upload_reader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ioctl_upload(ioctl_upload),
        .ioctl_rd    (ioctl_rd),
        .ioctl_addr  (ioctl_addr),
        .ioctl_index (ioctl_index),
        .ioctl_din   (ioctl_din),
        .ioctl_wait  (ioctl_wait),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .err         (err),
`ifdef UPLOAD_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .byte_count  (byte_count)
    );

    int         n_total = 0;
    int         n_bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_din;
    int         wait_run  = 0;
    int         last_wait = 0;

    // length of the most recent ioctl_wait pulse, in cycles
    always @(negedge clk) begin
        if (ioctl_wait) wait_run = wait_run + 1;
        else begin
            if (wait_run != 0) last_wait = wait_run;
            wait_run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] b, input bit delivered);
        exp_q.push_back(b);
        model_din = b;
`ifdef UPLOAD_CHECKSUM_EN
        if (delivered) model_ck = model_ck + b;
`else
        if (delivered) model_din = b;
`endif
    endtask

    task automatic issue_rd(input logic [7:0] idx, input logic [24:0] addr);
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_rd    = 1'b1;
        tick();
        ioctl_rd    = 1'b0;
    endtask

    task automatic ack(input logic [7:0] d);
        mem_data = d;
        mem_ack  = 1'b1;
        tick();
        mem_ack  = 1'b0;
    endtask

    task automatic finish_rd(input string tag);
        logic [7:0] e;
        int n;
        n = 0;
        @(negedge clk);
        while (ioctl_wait && n < 400) begin
            @(negedge clk);
            n = n + 1;
        end
        chk({tag, "_wait"}, 32'(ioctl_wait), 32'd0);
        if (exp_q.size() == 0) chk({tag, "_q"}, 32'(exp_q.size()), 32'd1);
        else begin
            e = exp_q.pop_front();
            chk({tag, "_din"}, 32'(ioctl_din), 32'(e));
        end
    endtask

    task automatic new_session();
        ioctl_upload = 1'b0;
        tick();
        ioctl_upload = 1'b1;
        tick();
`ifdef UPLOAD_CHECKSUM_EN
        model_ck = 8'h00;
`endif
    endtask

    // valid read with a given ack delay; checks address, data, wait length and count
    task automatic good_rd(input string tag, input logic [7:0] idx, input logic [24:0] addr,
                           input logic [23:0] xaddr, input int dly, input logic [7:0] d,
                           input logic [24:0] xcnt);
        issue_rd(idx, addr);
        push_exp(d, 1'b1);
        @(negedge clk);
        chk({tag, "_mrd"}, 32'(mem_rd), 32'd1);
        chk({tag, "_maddr"}, 32'(mem_addr), 32'(xaddr));
        repeat (dly) tick();
        if (dly == 0) tick();
        ack(d);
        finish_rd(tag);
        chk({tag, "_mrd_off"}, 32'(mem_rd), 32'd0);
        chk({tag, "_cnt"}, 32'(byte_count), 32'(xcnt));
        tick();
        chk({tag, "_wlen"}, 32'(last_wait), 32'((dly == 0) ? 2 : dly + 1));
    endtask

    // rejected access: fill byte, one-cycle stall, no memory cycle
    task automatic bad_rd(input string tag, input logic [7:0] idx, input logic [24:0] addr);
        issue_rd(idx, addr);
        push_exp(8'hFF, 1'b1);
        @(negedge clk);
        chk({tag, "_mrd"}, 32'(mem_rd), 32'd0);
        finish_rd(tag);
        chk({tag, "_err"}, 32'(err), 32'd1);
        tick();
        chk({tag, "_wlen"}, 32'(last_wait), 32'd1);
    endtask

    initial begin
        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        ioctl_index  = '0;
        mem_ack      = 1'b0;
        mem_data     = '0;
        model_din    = 8'h00;
`ifdef UPLOAD_CHECKSUM_EN
        model_ck     = 8'h00;
`endif
        repeat (3) tick();
        chk("rst_din",  32'(ioctl_din),  32'h00);
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_mrd",  32'(mem_rd),     32'd0);
        chk("rst_addr", 32'(mem_addr),   32'd0);
        chk("rst_err",  32'(err),        32'd0);
        chk("rst_cnt",  32'(byte_count), 32'd0);
        reset_n = 1'b1;
        new_session();

        // dly 3: ack sampled 4 cycles after the read; dly 0 is handled as ack on the next cycle
        good_rd("ram_a5",  8'd0, 25'h0000010, 24'h000010, 3, 8'hA5, 25'd1);
        // fastest path: ack on the cycle right after the request
        issue_rd(8'd0, 25'h0000020);
        push_exp(8'h3C, 1'b1);
        ack(8'h3C);
        finish_rd("fast");
        chk("fast_cnt", 32'(byte_count), 32'd2);
        tick();
        chk("fast_wlen", 32'(last_wait), 32'd1);

        good_rd("vram4",   8'd1, 25'h0000004, 24'h010004, 1, 8'h5A, 25'd3);
        good_rd("ram_top", 8'd0, 25'h000FFFF, 24'h00FFFF, 2, 8'hC3, 25'd4);
        chk("pre_bad_err", 32'(err), 32'd0);
        bad_rd("vram_oob", 8'd1, 25'h0004000);
        chk("vram_oob_cnt", 32'(byte_count), 32'd4);

        new_session();
        chk("sess_err", 32'(err), 32'd0);
        chk("sess_cnt", 32'(byte_count), 32'd0);
        bad_rd("ram_oob", 8'd0, 25'h0010000);
        new_session();
        bad_rd("addr25",  8'd0, 25'h1000010);
        new_session();
        bad_rd("idx2",    8'd2, 25'h0000000);

        // ack never comes: fill byte after ACK_TIMEOUT cycles, late ack drained
        new_session();
        issue_rd(8'd0, 25'h0000100);
        push_exp(8'hFF, 1'b1);
        finish_rd("tmo");
        chk("tmo_mrd", 32'(mem_rd), 32'd1);
        chk("tmo_err", 32'(err), 32'd1);
        tick();
        chk("tmo_wlen", 32'(last_wait), 32'd255);
        ack(8'h77);
        chk("drain_mrd", 32'(mem_rd), 32'd0);
        chk("drain_din", 32'(ioctl_din), 32'hFF);
        chk("drain_cnt", 32'(byte_count), 32'd0);
        good_rd("post_drain", 8'd0, 25'h0000001, 24'h000001, 1, 8'h11, 25'd1);

        // upload withdrawn mid-request
        new_session();
        issue_rd(8'd0, 25'h0000002);
        tick();
        ioctl_upload = 1'b0;
        push_exp(model_din, 1'b0);
        finish_rd("drop");
        chk("drop_mrd", 32'(mem_rd), 32'd1);
        ack(8'h99);
        chk("drop_mrd_off", 32'(mem_rd), 32'd0);
        chk("drop_din", 32'(ioctl_din), 32'h11);
        ioctl_upload = 1'b1;
        tick();
        chk("drop_newcnt", 32'(byte_count), 32'd0);
        good_rd("drop_next", 8'd0, 25'h0000003, 24'h000003, 1, 8'h42, 25'd1);

        // second strobe during a stalled read
        new_session();
        issue_rd(8'd0, 25'h0000005);
        push_exp(8'h6B, 1'b1);
        tick();
        ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        ack(8'h6B);
        finish_rd("dbl");
        chk("dbl_err", 32'(err), 32'd1);
        chk("dbl_cnt", 32'(byte_count), 32'd1);
        chk("dbl_addr", 32'(mem_addr), 32'h000005);

        // strobe with upload low does nothing
        new_session();
        ioctl_upload = 1'b0;
        tick();
        issue_rd(8'd0, 25'h0000006);
        @(negedge clk);
        chk("noup_wait", 32'(ioctl_wait), 32'd0);
        chk("noup_mrd",  32'(mem_rd), 32'd0);
        chk("noup_err",  32'(err), 32'd0);

        // reset in the middle of a request, stale ack afterwards
        ioctl_upload = 1'b1;
        tick();
        issue_rd(8'd0, 25'h0000007);
        tick();
        reset_n = 1'b0;
        tick();
        chk("mrst_mrd",  32'(mem_rd), 32'd0);
        chk("mrst_wait", 32'(ioctl_wait), 32'd0);
        chk("mrst_din",  32'(ioctl_din), 32'h00);
        reset_n = 1'b1;
        model_din = 8'h00;
        ack(8'h55);
        tick();
        chk("stale_din", 32'(ioctl_din), 32'h00);
        chk("stale_cnt", 32'(byte_count), 32'd0);
        chk("stale_mrd", 32'(mem_rd), 32'd0);

`ifdef UPLOAD_CHECKSUM_EN
        new_session();
        good_rd("ck80", 8'd0, 25'h0000008, 24'h000008, 1, 8'h80, 25'd1);
        good_rd("ck90", 8'd0, 25'h0000009, 24'h000009, 1, 8'h90, 25'd2);
        good_rd("ck10", 8'd0, 25'h000000A, 24'h00000A, 1, 8'h10, 25'd3);
        chk("cksum", 32'(checksum), 32'h20);
        bad_rd("ck_ff", 8'd3, 25'h0000000);
        chk("cksum_ff", 32'(checksum), 32'(model_ck));
`endif

        chk("q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

endmodule

// File: doc/ioctl_upload_reader.md
IOCTL_UPLOAD_READER -- requirements
Module: ioctl_upload_reader

Interface
REQ-001 Parameter RAM_BASE, default 24'h000000, memory base address for ioctl_index 0 (main RAM).
REQ-002 Parameter RAM_SIZE, default 25'h0010000, byte length of region 0.
REQ-003 Parameter VRAM_BASE, default 24'h010000, memory base address for ioctl_index 1 (video RAM).
REQ-004 Parameter VRAM_SIZE, default 25'h0004000, byte length of region 1.
REQ-005 Parameter ACK_TIMEOUT, default 8'd255, maximum cycles to wait for mem_ack.
REQ-006 clk  in  1  single clock; all logic rising-edge; reset_n  in  1  synchronous, active-low reset.
REQ-007 ioctl_upload  in  1  upload session active; ioctl_rd  in  1  one-cycle byte read strobe.
REQ-008 ioctl_addr  in  25  byte offset within region; ioctl_index  in  8  region select.
REQ-009 ioctl_din  out  8  byte returned to host; ioctl_wait  out  1  host must stall while high.
REQ-010 mem_rd  out  1  memory read request; mem_addr  out  24  memory byte address.
REQ-011 mem_ack  in  1  one-cycle read completion; mem_data  in  8  read data, valid with mem_ack.
REQ-012 err  out  1  sticky error flag; byte_count  out  25  bytes served this session.

Function
REQ-013 FSM states IDLE, REQ, DRAIN; all outputs registered.
REQ-014 In IDLE, when ioctl_rd is high and ioctl_upload is high, the block latches ioctl_addr and ioctl_index and asserts ioctl_wait on the next cycle.
REQ-015 Valid access: index 0 with addr < RAM_SIZE, or index 1 with addr < VRAM_SIZE; then mem_addr = base + addr[23:0], mem_rd = 1, and the state is REQ.
REQ-016 Invalid access: there is no memory cycle; ioctl_din = 8'hFF; ioctl_wait is high for exactly one cycle; err is set; the state stays IDLE.
REQ-017 In REQ, mem_rd and mem_addr hold stable until mem_ack; mem_ack arriving on the cycle after the request is legal.
REQ-018 On mem_ack in REQ: ioctl_din <= mem_data, mem_rd <= 0, ioctl_wait <= 0, byte_count increments, and the state is IDLE.
REQ-019 Minimum read latency is 2 cycles from ioctl_rd to ioctl_wait low with valid ioctl_din.
REQ-020 A timeout counter runs in REQ; when it reaches ACK_TIMEOUT without mem_ack: ioctl_din = 8'hFF, ioctl_wait = 0, err = 1, mem_rd stays high, and the state is DRAIN.
REQ-021 In DRAIN, the late mem_ack is consumed and its data discarded; mem_rd drops and the state is IDLE.
REQ-022 ioctl_rd while ioctl_wait is high, or while in DRAIN, is ignored and sets err.
REQ-023 ioctl_upload falling while in REQ: the memory request is not withdrawn; the state is DRAIN; ioctl_wait drops immediately.
REQ-024 ioctl_upload rising clears byte_count, err and the checksum.
REQ-025 ioctl_rd with ioctl_upload low is ignored and has no effect.
REQ-026 Address arithmetic is 24-bit wrap-around; the range check uses the full 25-bit ioctl_addr.

Reset
REQ-027 reset_n low on a clk edge forces: state IDLE, ioctl_din 8'h00, ioctl_wait 0, mem_rd 0, mem_addr 0, err 0, byte_count 0, timeout counter 0.
REQ-028 Reset mid-REQ drops mem_rd immediately; the memory arbiter owner guarantees that a stale mem_ack after reset is harmless, and it is ignored in IDLE.

Configuration
REQ-029 Macro UPLOAD_CHECKSUM_EN defined: output checksum [7:0] accumulates an 8-bit wrapping sum of every byte delivered on ioctl_din, including 8'hFF error bytes, and resets per REQ-024/REQ-027.
REQ-030 Macro UPLOAD_CHECKSUM_EN undefined: the checksum port and its logic are absent; all other behaviour is identical.

Structure
REQ-031 Shared package laser500_pkg holds the FSM state enum, region index constants (IDX_RAM = 0, IDX_VRAM = 1) and the 8'hFF fill byte constant.
REQ-032 The block is a single module; the timeout counter is inline, and no sub-module is required.

Verification
REQ-033 Index 0, addr 0x0010, memory returns 8'hA5 with mem_ack 3 cycles after mem_rd -> mem_addr = 24'h000010; ioctl_din = 8'hA5; ioctl_wait high 4 cycles; byte_count = 1.
REQ-034 Index 1, addr 0x0004 -> mem_addr = 24'h010004; index 1, addr 0x4000 -> no mem_rd; ioctl_din = 8'hFF; err = 1.
REQ-035 Index 0, mem_ack never arrives -> after ACK_TIMEOUT cycles ioctl_din = 8'hFF and ioctl_wait = 0; a later mem_ack is consumed in DRAIN and mem_rd drops.
REQ-036 ioctl_upload dropped while in REQ, then mem_ack -> ioctl_din unchanged; state IDLE; next session byte_count = 0.
REQ-037 Second ioctl_rd during ioctl_wait -> ignored; err = 1; first read completes normally.
REQ-038 With UPLOAD_CHECKSUM_EN, reads returning 8'h80, 8'h90, 8'h10 -> checksum = 8'h20.
